instr_fetch_unit: RTL and testbench

- Requester side of the instruction-memory bus: drives the byte address into the synchronous 256x8 program memory and collects the returned bytes.
- Memory contract: the address is sampled on a CLK rising edge; the data is valid after that edge.
- Buffers fetched bytes, each tagged with its address, in a small prefetch queue feeding the processor decoder.
- Supports redirect (branch/jump/interrupt vector) with flush of all stale data.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/instr_fetch_unit_if.sv | 44 ++++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults, FSM encoding and queue entry layout for the instruction fetch unit.
package fetch_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_RESET_PC   = 'h00;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Program-memory bus plus decoder-side queue head, as seen by the fetch unit (master)
// and by the memory/decoder environment (slave).
interface instr_fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int OCC_WIDTH  = 3
);
    logic [ADDR_WIDTH-1:0] ROM_ADDR;
    logic [DATA_WIDTH-1:0] ROM_DATA;
    logic                  BRANCH_VALID;
    logic [ADDR_WIDTH-1:0] BRANCH_ADDR;
    logic                  INSTR_READY;
    logic                  INSTR_VALID;
    logic [DATA_WIDTH-1:0] INSTR_DATA;
    logic [ADDR_WIDTH-1:0] INSTR_ADDR;
    logic [OCC_WIDTH-1:0]  OCC;

    modport master (
        output ROM_ADDR,
        input  ROM_DATA,
        input  BRANCH_VALID,
        input  BRANCH_ADDR,
        input  INSTR_READY,
        output INSTR_VALID,
        output INSTR_DATA,
        output INSTR_ADDR,
        output OCC
    );

    modport slave (
        input  ROM_ADDR,
        output ROM_DATA,
        output BRANCH_VALID,
        output BRANCH_ADDR,
        output INSTR_READY,
        input  INSTR_VALID,
        input  INSTR_DATA,
        input  INSTR_ADDR,
        input  OCC
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO with clear; the head reads as zero when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DEFAULT_ADDR_WIDTH + DEFAULT_DATA_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       push_data,
    output logic                   head_valid,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !clear;
    assign do_pop  = pop && (count != '0) && !clear;

    // NOTE: the storage array is deliberately not reset; validity lives in count, and the head is masked while empty.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives the program-memory address, tracks the in-flight byte,
// and fills the prefetch queue under a credit limit that counts the in-flight byte.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                CLK,
    input  logic                RESET,
    instr_fetch_unit_if.master  bus
);
    localparam int OCC_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] tag;
    logic                  pending;
    logic [OCC_W-1:0]      occ;
    logic [OCC_W-1:0]      occ_next;
    logic [OCC_W-1:0]      credit_used;
    logic [OCC_W-1:0]      credit_next;
    logic                  issue;
    logic                  capture;
    logic                  pop;
    logic                  head_valid;
    logic [ENTRY_W-1:0]    head_entry;

    // A redirect overrides issue, capture and pop on the same edge.
    assign credit_used = occ + OCC_W'(pending);
    assign issue       = (state == FETCH) && (credit_used < OCC_W'(DEPTH)) && !bus.BRANCH_VALID;
    assign capture     = pending && !bus.BRANCH_VALID;
    assign pop         = head_valid && bus.INSTR_READY && !bus.BRANCH_VALID;
    assign occ_next    = occ + OCC_W'(capture) - OCC_W'(pop);
    assign credit_next = occ_next + OCC_W'(issue);

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        if (bus.BRANCH_VALID) begin
            state_next = FLUSH;
        end else begin
            case (state)
                FETCH, STALL: state_next = (credit_next >= OCC_W'(DEPTH)) ? STALL : FETCH;
                FLUSH:        state_next = FETCH;
                default:      state_next = FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            tag      <= '0;
            pending  <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= issue;
            if (bus.BRANCH_VALID) begin
                fetch_pc <= bus.BRANCH_ADDR;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 1'b1;
                tag      <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .CLK        (CLK),
        .RESET      (RESET),
        .push       (capture),
        .pop        (pop),
        .clear      (bus.BRANCH_VALID),
        .push_data  ({tag, bus.ROM_DATA}),
        .head_valid (head_valid),
        .head_data  (head_entry),
        .count      (occ)
    );

    assign bus.ROM_ADDR                   = fetch_pc;
    assign bus.INSTR_VALID                = head_valid;
    assign {bus.INSTR_ADDR, bus.INSTR_DATA} = head_entry;
    assign bus.OCC                        = occ;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: ROM model holding byte k at address k,
// expected {addr, data} stream queued on stimulus and compared as the decoder pops.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    instr_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OCC_WIDTH(OW)) bus ();

    instr_fetch_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .RESET_PC   (8'h00)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    logic [7:0] rom [256];
    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    end

    // Synchronous program memory: address sampled on the edge, data valid after it.
    always @(posedge CLK) bus.ROM_DATA <= rom[bus.ROM_ADDR];

    int tests = 0;
    int fails = 0;
    int pops  = 0;
    int p0;
    fetch_entry_t sb_q[$];
    fetch_entry_t exp_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_load(input logic [7:0] start, input int n);
        fetch_entry_t e;
        sb_q.delete();
        for (int i = 0; i < n; i++) begin
            e.addr = start + 8'(i);
            e.data = rom[e.addr];
            sb_q.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Decoder-side monitor: a pop happens on the next edge unless a redirect overrides it.
    always @(negedge CLK) begin
        if (RESET && bus.INSTR_VALID && bus.INSTR_READY && !bus.BRANCH_VALID) begin
            if (sb_q.size() == 0) begin
                check("sb_extra_byte", 32'(bus.INSTR_ADDR), 32'hFFFF_FFFF);
            end else begin
                exp_e = sb_q.pop_front();
                check("head_addr", 32'(bus.INSTR_ADDR), 32'(exp_e.addr));
                check("head_data", 32'(bus.INSTR_DATA), 32'(exp_e.data));
            end
            pops++;
        end
    end

    initial begin
        RESET            = 1'b0;
        bus.BRANCH_VALID = 1'b0;
        bus.BRANCH_ADDR  = '0;
        bus.INSTR_READY  = 1'b1;
        #3;
        check("rst_valid", 32'(bus.INSTR_VALID), 0);
        check("rst_data",  32'(bus.INSTR_DATA), 0);
        check("rst_addr",  32'(bus.INSTR_ADDR), 0);
        check("rst_occ",   32'(bus.OCC), 0);
        check("rst_rom",   32'(bus.ROM_ADDR), 0);

        // Streaming from reset with the decoder always ready.
        sb_load(8'h00, 40);
        tick(1);
        RESET = 1'b1;
        tick(1);
        check("t1_valid_e1", 32'(bus.INSTR_VALID), 0);
        tick(1);
        check("t1_valid_e2", 32'(bus.INSTR_VALID), 1);
        check("t1_addr_e2",  32'(bus.INSTR_ADDR), 0);
        p0 = pops;
        tick(16);
        check("t1_rate", pops - p0, 16);

        // Decoder stalled from reset: queue saturates, fetch holds.
        RESET = 1'b0;
        bus.INSTR_READY = 1'b0;
        #1;
        sb_load(8'h00, 40);
        tick(1);
        RESET = 1'b1;
        tick(8);
        check("t2_occ_full",  32'(bus.OCC), 4);
        check("t2_head_addr", 32'(bus.INSTR_ADDR), 0);
        check("t2_rom_hold",  32'(bus.ROM_ADDR), 4);
        tick(4);
        check("t2_rom_hold2", 32'(bus.ROM_ADDR), 4);
        check("t2_occ_full2", 32'(bus.OCC), 4);
        bus.INSTR_READY = 1'b1;
        tick(1);
        check("t2_occ_pop", 32'(bus.OCC), 3);
        check("t2_rom_nopush", 32'(bus.ROM_ADDR), 4);
        tick(1);
        check("t2_refill", 32'(bus.ROM_ADDR), 5);
        tick(8);

        // Redirect during streaming, coincident with a pop and a capture.
        bus.BRANCH_VALID = 1'b1;
        bus.BRANCH_ADDR  = 8'h40;
        sb_load(8'h40, 40);
        tick(1);
        bus.BRANCH_VALID = 1'b0;
        check("t3_occ_flush", 32'(bus.OCC), 0);
        check("t3_valid_a",   32'(bus.INSTR_VALID), 0);
        tick(1);
        check("t3_valid_b", 32'(bus.INSTR_VALID), 0);
        check("t3_rom_tgt", 32'(bus.ROM_ADDR), 'h40);
        tick(1);
        check("t3_valid_c", 32'(bus.INSTR_VALID), 0);
        tick(1);
        check("t3_valid_d", 32'(bus.INSTR_VALID), 1);
        check("t3_addr_d",  32'(bus.INSTR_ADDR), 'h40);
        tick(6);

        // Redirect near the top of the address space wraps.
        bus.BRANCH_VALID = 1'b1;
        bus.BRANCH_ADDR  = 8'hFE;
        sb_load(8'hFE, 40);
        p0 = pops;
        tick(1);
        bus.BRANCH_VALID = 1'b0;
        tick(3);
        check("t4_addr_fe", 32'(bus.INSTR_ADDR), 'hFE);
        tick(6);
        check("t4_pops", pops - p0, 6);

        // Back-to-back redirects: only the second target stream survives.
        bus.BRANCH_VALID = 1'b1;
        bus.BRANCH_ADDR  = 8'h40;
        sb_load(8'h40, 40);
        tick(1);
        bus.BRANCH_ADDR  = 8'h80;
        sb_load(8'h80, 40);
        tick(1);
        bus.BRANCH_VALID = 1'b0;
        check("t5_occ",   32'(bus.OCC), 0);
        check("t5_valid", 32'(bus.INSTR_VALID), 0);
        tick(3);
        check("t5_valid_tgt", 32'(bus.INSTR_VALID), 1);
        check("t5_addr_tgt",  32'(bus.INSTR_ADDR), 'h80);
        tick(6);

        // Asynchronous reset with three queued bytes and one in flight.
        bus.INSTR_READY  = 1'b0;
        bus.BRANCH_VALID = 1'b1;
        bus.BRANCH_ADDR  = 8'h20;
        sb_load(8'h20, 40);
        tick(1);
        bus.BRANCH_VALID = 1'b0;
        tick(5);
        check("t6_pre_occ", 32'(bus.OCC), 3);
        check("t6_pre_rom", 32'(bus.ROM_ADDR), 'h24);
        #2;
        RESET = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.INSTR_VALID), 0);
        check("t6_rst_occ",   32'(bus.OCC), 0);
        check("t6_rst_data",  32'(bus.INSTR_DATA), 0);
        check("t6_rst_addr",  32'(bus.INSTR_ADDR), 0);
        check("t6_rst_rom",   32'(bus.ROM_ADDR), 0);
        sb_load(8'h00, 40);
        tick(2);
        check("t6_no_capture", 32'(bus.OCC), 0);
        bus.INSTR_READY = 1'b1;
        RESET = 1'b1;
        tick(1);
        check("t6_valid_e1", 32'(bus.INSTR_VALID), 0);
        tick(1);
        check("t6_valid_e2", 32'(bus.INSTR_VALID), 1);
        check("t6_addr_e2",  32'(bus.INSTR_ADDR), 0);
        p0 = pops;
        tick(6);
        check("t6_rate", pops - p0, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
